// File: rtl/sram_client_sequencer.sv
// Runs the enabled SRAM clients one after another and muxes the shared SRAM bus.
// Define SEQ_TIMEOUT_EN to add a per-client watchdog that aborts a stuck sequence.
module sram_client_sequencer #(
    parameter int unsigned NUM_CLIENTS    = 3,
    parameter int unsigned ADDR_W         = 18,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    localparam int unsigned CIDX_W        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                          Clock,
    input  logic                          Resetn,
    input  logic                          Trigger,
    input  logic [NUM_CLIENTS-1:0]        Client_mask,
    output logic [NUM_CLIENTS-1:0]        Client_start,
    input  logic [NUM_CLIENTS-1:0]        Client_stop,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] Client_SRAM_address,
    input  logic [NUM_CLIENTS*DATA_W-1:0] Client_SRAM_write_data,
    input  logic [NUM_CLIENTS-1:0]        Client_SRAM_we_n,
    input  logic [ADDR_W-1:0]             Idle_SRAM_address,
    output logic [ADDR_W-1:0]             SRAM_address,
    output logic [DATA_W-1:0]             SRAM_write_data,
    output logic                          SRAM_we_n,
    output logic                          Idle_enable,
    output logic                          Busy,
    output logic [CIDX_W-1:0]             Active_client,
    output logic                          Done,
    output logic                          Timeout_error
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [CIDX_W-1:0]       idx_q, idx_d;
    logic [NUM_CLIENTS-1:0]  mask_q, mask_d;
    logic                    done_q, done_d;
    logic                    idle_en_q, idle_en_d;

    logic                    first_found, next_found;
    logic [CIDX_W-1:0]       first_idx, next_idx;
    logic [ADDR_W-1:0]       cl_addr;
    logic [DATA_W-1:0]       cl_data;
    logic                    cl_we_n;
    logic                    cl_stop;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // Descending scan so the lowest qualifying bit is the one left standing.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = int'(NUM_CLIENTS) - 1; i >= 0; i--) begin
            if (Client_mask[i]) begin
                first_found = 1'b1;
                first_idx   = CIDX_W'(i);
            end
            if (mask_q[i] && (CIDX_W'(i) > idx_q)) begin
                next_found = 1'b1;
                next_idx   = CIDX_W'(i);
            end
        end
    end

    always_comb begin
        cl_addr = '0;
        cl_data = '0;
        cl_we_n = 1'b1;
        cl_stop = 1'b0;
        for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
            if (idx_q == CIDX_W'(i)) begin
                cl_addr = Client_SRAM_address[i*ADDR_W +: ADDR_W];
                cl_data = Client_SRAM_write_data[i*DATA_W +: DATA_W];
                cl_we_n = Client_SRAM_we_n[i];
                cl_stop = Client_stop[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        done_d    = 1'b0;
        idle_en_d = idle_en_q;
`ifdef SEQ_TIMEOUT_EN
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Trigger) begin
                    mask_d    = Client_mask;
                    idle_en_d = 1'b0;
                    if (first_found) begin
                        idx_d   = first_idx;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                // Stop wins over a watchdog expiry in the same cycle.
                if (cl_stop) begin
                    if (next_found) begin
                        idx_d   = next_idx;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wd_cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
`endif
            end
            S_DONE: begin
                done_d    = 1'b1;
                idle_en_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            mask_q    <= '0;
            done_q    <= 1'b0;
            idle_en_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            done_q    <= done_d;
            idle_en_q <= idle_en_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign Timeout_error = timeout_q;
`else
    assign Timeout_error = 1'b0;
`endif

    always_comb begin
        Client_start = '0;
        for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
            if ((state_q == S_LAUNCH) && (idx_q == CIDX_W'(i))) begin
                Client_start[i] = 1'b1;
            end
        end
    end

    assign Busy            = (state_q == S_LAUNCH) || (state_q == S_WAIT);
    assign Active_client   = Busy ? idx_q : '0;
    assign SRAM_address    = Busy ? cl_addr : Idle_SRAM_address;
    assign SRAM_write_data = Busy ? cl_data : '0;
    assign SRAM_we_n       = Busy ? cl_we_n : 1'b1;
    assign Done            = done_q;
    assign Idle_enable     = idle_en_q;

endmodule

// File: tb/tb_sram_client_sequencer.sv
// Self-checking bench for sram_client_sequencer: a cycle model predicts every output,
// with the expected client order held in a scoreboard queue.
module tb_sram_client_sequencer;

    localparam int NC = 3;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int TO = 16;

    logic             Clock = 1'b0;
    logic             Resetn = 1'b0;
    logic             Trigger = 1'b0;
    logic [NC-1:0]    Client_mask = '0;
    logic [NC-1:0]    Client_start;
    logic [NC-1:0]    Client_stop = '0;
    logic [NC*AW-1:0] Client_SRAM_address = '0;
    logic [NC*DW-1:0] Client_SRAM_write_data = '0;
    logic [NC-1:0]    Client_SRAM_we_n = 3'b010;
    logic [AW-1:0]    Idle_SRAM_address = 18'h0abc;
    logic [AW-1:0]    SRAM_address;
    logic [DW-1:0]    SRAM_write_data;
    logic             SRAM_we_n;
    logic             Idle_enable;
    logic             Busy;
    logic [1:0]       Active_client;
    logic             Done;
    logic             Timeout_error;

    int checks = 0;
    int errors = 0;
    bit timeout_sticky = 1'b0;

    logic [AW-1:0] addr  [NC];
    logic [DW-1:0] wdata [NC];
    logic [NC-1:0] we_pat = 3'b010;

    sram_client_sequencer #(
        .NUM_CLIENTS    (NC),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clock                  (Clock),
        .Resetn                 (Resetn),
        .Trigger                (Trigger),
        .Client_mask            (Client_mask),
        .Client_start           (Client_start),
        .Client_stop            (Client_stop),
        .Client_SRAM_address    (Client_SRAM_address),
        .Client_SRAM_write_data (Client_SRAM_write_data),
        .Client_SRAM_we_n       (Client_SRAM_we_n),
        .Idle_SRAM_address      (Idle_SRAM_address),
        .SRAM_address           (SRAM_address),
        .SRAM_write_data        (SRAM_write_data),
        .SRAM_we_n              (SRAM_we_n),
        .Idle_enable            (Idle_enable),
        .Busy                   (Busy),
        .Active_client          (Active_client),
        .Done                   (Done),
        .Timeout_error          (Timeout_error)
    );

    always #5 Clock = ~Clock;

    // Runs one sequence against a cycle model. Returns the cycle (after Trigger) on which
    // Done is expected, or -2 if the run was cut short by a reset in the aborting client.
    task automatic run_seq(input logic [NC-1:0] mask, input int delay, input bit preheld,
                           input int hang, input int abort_c, input bit glitch,
                           output int done_at);
        int            q[$];
        int            cur, wait_cnt, done_e, abort_cnt;
        int            cnt [NC];
        logic [NC-1:0] stop, exp_start;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic          exp_we;
        bit            busy_e, in_seq, prev_start, start_e, leave;

        @(negedge Clock);
        for (int i = 0; i < NC; i++) begin
            addr[i]  = AW'($urandom);
            wdata[i] = DW'($urandom);
            cnt[i]   = -1;
            Client_SRAM_address[i*AW +: AW]    = addr[i];
            Client_SRAM_write_data[i*DW +: DW] = wdata[i];
            if (mask[i]) q.push_back(i);
        end
        Client_SRAM_we_n  = we_pat;
        Idle_SRAM_address = AW'($urandom);
        stop        = preheld ? mask : '0;
        Client_stop = stop;
        Client_mask = mask;
        Trigger     = 1'b1;
        cur = 0; wait_cnt = 0; done_e = -1; abort_cnt = -1; done_at = -1;
        busy_e = 1'b0; in_seq = 1'b0; prev_start = 1'b0;

        for (int j = 1; j <= 300; j++) begin
            @(negedge Clock);
            start_e = 1'b0;
            leave   = 1'b0;
            if (j == 1) begin
                in_seq = 1'b1;
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    start_e = 1'b1;
                end else begin
                    done_e = 2;
                end
            end else if (busy_e && !prev_start) begin
                if (stop[cur]) begin
                    leave = 1'b1;
                end else begin
                    wait_cnt++;
                    if (cur == hang && wait_cnt == TO) begin
                        leave = 1'b1;
                        q.delete();
                        timeout_sticky = 1'b1;
                    end
                end
                if (leave) begin
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        start_e = 1'b1;
                    end else begin
                        busy_e = 1'b0;
                        done_e = j + 1;
                    end
                end
            end
            if (start_e) begin
                busy_e   = 1'b1;
                wait_cnt = 0;
            end
            if (j == done_e) in_seq = 1'b0;

            exp_start = start_e ? (NC'(1) << cur) : '0;
            exp_addr  = busy_e ? addr[cur] : Idle_SRAM_address;
            exp_data  = busy_e ? wdata[cur] : '0;
            exp_we    = busy_e ? we_pat[cur] : 1'b1;

            checks++;
            if (Client_start !== exp_start) begin
                errors++;
                $display("FAIL start cyc=%0d got=%b want=%b", j, Client_start, exp_start);
            end
            checks++;
            if (Busy !== busy_e) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b want=%b", j, Busy, busy_e);
            end
            checks++;
            if (Active_client !== (busy_e ? 2'(cur) : 2'd0)) begin
                errors++;
                $display("FAIL active cyc=%0d got=%0d want=%0d", j, Active_client,
                         busy_e ? cur : 0);
            end
            checks++;
            if (Done !== (j == done_e)) begin
                errors++;
                $display("FAIL done cyc=%0d got=%b want=%b", j, Done, (j == done_e));
            end
            checks++;
            if (Idle_enable !== !in_seq) begin
                errors++;
                $display("FAIL idle_en cyc=%0d got=%b want=%b", j, Idle_enable, !in_seq);
            end
            checks++;
            if (Timeout_error !== timeout_sticky) begin
                errors++;
                $display("FAIL timeout cyc=%0d got=%b want=%b", j, Timeout_error,
                         timeout_sticky);
            end
            checks++;
            if ({SRAM_address, SRAM_write_data, SRAM_we_n} !== {exp_addr, exp_data, exp_we})
            begin
                errors++;
                $display("FAIL bus cyc=%0d got=%h/%h/%b want=%h/%h/%b", j, SRAM_address,
                         SRAM_write_data, SRAM_we_n, exp_addr, exp_data, exp_we);
            end

            if (start_e && cur == abort_c) abort_cnt = 0;
            else if (abort_cnt >= 0) abort_cnt++;
            if (abort_cnt == 2) begin
                Resetn  = 1'b0;
                Trigger = 1'b0;
                done_at = -2;
                return;
            end

            for (int i = 0; i < NC; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) stop[i] = 1'b1;
                end
            end
            if (start_e && !preheld) begin
                stop[cur] = 1'b0;
                cnt[cur]  = (cur == hang) ? -1 : delay;
            end
            prev_start  = start_e;
            Client_stop = stop;
            Trigger     = glitch && (j == 2);
            if (j == 1) Client_mask = ~mask;

            if (j == done_e) begin
                done_at = j;
                break;
            end
        end
        Trigger = 1'b0;
        checks++;
        if (done_at < 0) begin
            errors++;
            $display("FAIL seq_bound got=no_done want=done_within_300");
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got=%0d want=0", q.size());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({Busy, Done, Idle_enable, Client_start, Timeout_error, SRAM_we_n, Active_client}
            !== {1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL reset_outputs got=%b%b%b%b%b%b%b want=0010000100", Busy, Done,
                     Idle_enable, Client_start, Timeout_error, SRAM_we_n, Active_client);
        end
        checks++;
        if (SRAM_address !== Idle_SRAM_address || SRAM_write_data !== '0) begin
            errors++;
            $display("FAIL reset_bus got=%h/%h want=%h/0", SRAM_address, SRAM_write_data,
                     Idle_SRAM_address);
        end
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic test_all_clients();
        int d;
        run_seq(3'b111, 5, 1'b0, -1, -1, 1'b1, d);
        checks++;
        if (d !== 20) begin
            errors++;
            $display("FAIL all_clients_latency got=%0d want=20", d);
        end
    endtask

    task automatic test_sparse_mask();
        int d;
        run_seq(3'b101, 5, 1'b0, -1, -1, 1'b1, d);
        checks++;
        if (d !== 14) begin
            errors++;
            $display("FAIL sparse_latency got=%0d want=14", d);
        end
    endtask

    task automatic test_empty_mask();
        int d;
        run_seq(3'b000, 5, 1'b0, -1, -1, 1'b0, d);
        checks++;
        if (d !== 2) begin
            errors++;
            $display("FAIL empty_latency got=%0d want=2", d);
        end
    endtask

    task automatic test_stop_preheld();
        int d;
        run_seq(3'b001, 0, 1'b1, -1, -1, 1'b0, d);
        checks++;
        if (d !== 4) begin
            errors++;
            $display("FAIL preheld_one got=%0d want=4", d);
        end
        run_seq(3'b111, 0, 1'b1, -1, -1, 1'b0, d);
        checks++;
        if (d !== 8) begin
            errors++;
            $display("FAIL preheld_all got=%0d want=8", d);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        run_seq(3'b011, 2, 1'b0, -1, -1, 1'b0, d);
        checks++;
        if (d !== 8) begin
            errors++;
            $display("FAIL b2b_first got=%0d want=8", d);
        end
        run_seq(3'b110, 2, 1'b0, -1, -1, 1'b0, d);
        checks++;
        if (d !== 8) begin
            errors++;
            $display("FAIL b2b_second got=%0d want=8", d);
        end
    endtask

    task automatic test_reset_mid_sequence();
        int d;
        run_seq(3'b111, 5, 1'b0, -1, 1, 1'b0, d);
        #1;
        timeout_sticky = 1'b0;
        checks++;
        if (d !== -2) begin
            errors++;
            $display("FAIL abort_reached got=%0d want=-2", d);
        end
        checks++;
        if ({Busy, Done, Idle_enable, Client_start, Timeout_error, SRAM_we_n, Active_client}
            !== {1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL midreset_outputs got=%b%b%b%b%b%b%b want=0010000100", Busy, Done,
                     Idle_enable, Client_start, Timeout_error, SRAM_we_n, Active_client);
        end
        @(negedge Clock);
        checks++;
        if (SRAM_we_n !== 1'b1 || SRAM_address !== Idle_SRAM_address) begin
            errors++;
            $display("FAIL midreset_bus got=%b/%h want=1/%h", SRAM_we_n, SRAM_address,
                     Idle_SRAM_address);
        end
        Resetn = 1'b1;
        run_seq(3'b111, 5, 1'b0, -1, -1, 1'b0, d);
        checks++;
        if (d !== 20) begin
            errors++;
            $display("FAIL restart_latency got=%0d want=20", d);
        end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int d;
        run_seq(3'b111, 5, 1'b0, 1, -1, 1'b0, d);
        checks++;
        if (d !== 25) begin
            errors++;
            $display("FAIL timeout_latency got=%0d want=25", d);
        end
        @(negedge Clock);
        checks++;
        if (Timeout_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got=%b want=1", Timeout_error);
        end
        Resetn = 1'b0;
        #1;
        timeout_sticky = 1'b0;
        checks++;
        if (Timeout_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear got=%b want=0", Timeout_error);
        end
        @(negedge Clock);
        Resetn = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_all_clients();
        test_sparse_mask();
        test_empty_mask();
        test_stop_preheld();
        test_back_to_back();
        test_reset_mid_sequence();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
